// File: rtl/gray_word_if.sv
// Valid/ready bundle for the Gray-word decoder: Gray words in, binary words out.
interface gray_word_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_gray;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_bin;

  modport master (
    output in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin
  );

  modport slave (
    input  in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin
  );
endinterface

// File: rtl/gray_word_decoder.sv
// Bit-serial Gray-to-binary decoder: one bit per clock, MSB first, result held
// on a valid/ready port until consumed; counts delivered words for debug.
module gray_word_decoder #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  gray_word_if.slave    bus,
  output logic          busy,
  output logic [CW-1:0] word_count
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   g_reg;
  logic [W-1:0]   res;
  logic [W-1:0]   out_bin_q;
  logic           acc;
  logic [IW-1:0]  idx;
  logic           bit_d;
  logic           accept;
  logic           deliver;
  logic           last_bit;

  assign bit_d    = acc ^ g_reg[idx];
  assign last_bit = (idx == '0);
  assign accept   = (state_q == IDLE) && bus.in_valid;
  assign deliver  = (state_q == DONE) && bus.out_ready;
  assign bus.out_bin = out_bin_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (accept) state_d = DECODE;
      end
      DECODE: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (deliver) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // res is cleared on accept, so its bit 0 is still zero when the final bit
  // is folded in on the way to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_reg      <= '0;
      res        <= '0;
      acc        <= 1'b0;
      idx        <= '0;
      out_bin_q  <= '0;
      word_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            g_reg <= bus.in_gray;
            idx   <= IW'(W - 1);
            acc   <= 1'b0;
            res   <= '0;
          end
        end
        DECODE: begin
          acc <= bit_d;
          if (last_bit) begin
            out_bin_q <= res | W'(bit_d);
          end else begin
            res[idx] <= bit_d;
            idx      <= idx - IW'(1);
          end
        end
        DONE: begin
          if (deliver) word_count <= word_count + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_word_decoder.sv
// Randomized scoreboard bench for gray_word_decoder with an arithmetic
// Gray reference model; a second instance exercises counter wrap at CW=4.
module tb_gray_word_decoder;
  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, busy4;
  logic [15:0] word_count;
  logic [3:0]  word_count4;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int acc_cyc = 0;
  bit bp_en  = 1'b0;
  logic [W-1:0] exp_q[$];

  gray_word_if #(.W(W)) bus ();
  gray_word_if #(.W(W)) bus4 ();

  gray_word_decoder #(.W(W), .CW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .word_count(word_count)
  );

  gray_word_decoder #(.W(W), .CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4), .busy(busy4), .word_count(word_count4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] gray_enc(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary is the XOR of the Gray word with all of its right shifts.
  function automatic logic [W-1:0] gray_dec(input logic [W-1:0] g);
    logic [W-1:0] r = '0;
    for (int s = 0; s < W; s++) r = r ^ (g >> s);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    total++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Monitor: every output handshake pops one expected word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        timeout("unexpected_output");
      end else begin
        check("out_bin", bus.out_bin, exp_q.pop_front());
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    #1;
    if (bp_en) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic [W-1:0] g, input logic [W-1:0] expv);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_gray  = g;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) timeout("send_accept");
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_gray  = W'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a[4];
    int seen;
    logic [W-1:0] g;

    bus.in_valid = 1'b0; bus.in_gray = '0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_gray = '0; bus4.out_ready = 1'b1;
    do_reset();

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_bin", bus.out_bin, 0);
    check("rst_word_count", word_count, 0);

    // Latency and MSB-only boundary.
    send(8'h80, 8'hFF);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("latency_wait");
    check("latency", cyc - acc_cyc, W);
    @(posedge clk);
    #1;
    check("wc_after_first", word_count, 1);

    // Backpressure with upstream noise.
    bus.out_ready = 1'b0;
    send(8'hC0, 8'h80);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("bp_wait");
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_bin", bus.out_bin, 8'h80);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_gray  = W'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after", bus.in_ready, 1);
    check("bp_out_valid_after", bus.out_valid, 0);
    check("bp_wc", word_count, 2);

    // Back-to-back sequence: accepts spaced W+2 apart.
    do_reset();
    send(8'h00, 8'h00); a[0] = acc_cyc;
    send(8'hC0, 8'h80); a[1] = acc_cyc;
    send(8'h01, 8'h01); a[2] = acc_cyc;
    send(8'h55, 8'h66); a[3] = acc_cyc;
    for (int i = 1; i < 4; i++) check("accept_spacing", a[i] - a[i-1], W + 2);
    drain();
    check("wc_seq", word_count, 4);

    // Asynchronous reset during the third DECODE cycle.
    send(8'h55, 8'h66);
    repeat (2) @(posedge clk);
    #1;
    check("busy_before_abort", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_wc", word_count, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_stale", seen, 0);
    @(posedge clk);
    #1;

    // Exhaustive round trip under random backpressure.
    bp_en = 1'b1;
    for (int b = 0; b < 256; b++) send(gray_enc(W'(b)), W'(b));
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();
    check("wc_exhaustive", word_count, 256);

    // Counter wrap on the CW=4 instance.
    for (int k = 1; k <= 17; k++) begin
      g = W'($urandom);
      bus4.in_valid = 1'b1;
      bus4.in_gray  = g;
      n = 0;
      @(negedge clk);
      while (!bus4.in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) timeout("wrap_accept");
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      bus4.in_gray  = W'($urandom);
      n = 0;
      @(negedge clk);
      while (!bus4.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) timeout("wrap_out");
      check("wrap_out_bin", bus4.out_bin, gray_dec(g));
      @(posedge clk);
      #1;
      check("wrap_wc", word_count4, k % 16);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
